// File: rtl/proc_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MSTATUS_T,
    ST_W_MSTATUS_R,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_target_calc.sv
// Redirect target for trap entry (direct or vectored mtvec) or MRET (mepc).
module trap_target_calc #(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            is_mret_i,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_off;

  // Select between mepc, vectored interrupt slot and direct base.
  always_comb begin
    base    = mtvec_i & ALIGN_MASK;
    // Shifting the full cause drops the interrupt bit, leaving cause[XLEN-2:0]<<2 mod 2^XLEN.
    vec_off = cause_i << 2;
    if (is_mret_i) begin
      redirect_pc_o = mepc_i & ALIGN_MASK;
    end else if (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && cause_i[XLEN-1]) begin
      redirect_pc_o = base + vec_off;
    end else begin
      redirect_pc_o = base;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences trap entry / MRET CSR writes through one CSR write port, then redirects the PC.
module trap_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CSR_AW      = 12,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exc_valid_i,
  input  logic [XLEN-1:0]   exc_cause_i,
  input  logic [XLEN-1:0]   exc_pc_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              csr_req_o,
  input  logic              csr_gnt_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              busy_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            is_mret_q, is_mret_d;

  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_mret;
  logic [XLEN-1:0] target_pc;

  trap_target_calc #(
    .XLEN        (XLEN),
    .VECTORED_EN (VECTORED_EN)
  ) u_target (
    .mtvec_i       (mtvec_i),
    .cause_i       (cause_q),
    .mepc_i        (mepc_i),
    .is_mret_i     (is_mret_q),
    .redirect_pc_o (target_pc)
  );

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      tval_q    <= tval_d;
      is_mret_q <= is_mret_d;
    end
  end

  // Next-state and capture logic; writes advance only on grant.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    tval_d    = tval_q;
    is_mret_d = is_mret_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i) begin
          cause_d   = exc_cause_i;
          pc_d      = exc_pc_i;
          tval_d    = exc_tval_i;
          is_mret_d = 1'b0;
          state_d   = ST_W_MEPC;
        end else if (mret_i) begin
          is_mret_d = 1'b1;
          state_d   = ST_W_MSTATUS_R;
        end
      end
      ST_W_MEPC:      if (csr_gnt_i) state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:    if (csr_gnt_i) state_d = ST_W_MTVAL;
      ST_W_MTVAL:     if (csr_gnt_i) state_d = ST_W_MSTATUS_T;
      ST_W_MSTATUS_T: if (csr_gnt_i) state_d = ST_REDIRECT;
      ST_W_MSTATUS_R: if (csr_gnt_i) state_d = ST_REDIRECT;
      ST_REDIRECT:    state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // CSR write port, stall, flush and redirect outputs decoded from state.
  always_comb begin
    ms_trap = mstatus_i;
    ms_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
    ms_trap[MSTATUS_MIE]  = 1'b0;
    ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    ms_mret = mstatus_i;
    ms_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
    ms_mret[MSTATUS_MPIE] = 1'b1;
    ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    csr_req_o        = 1'b0;
    csr_addr_o       = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = (state_q != ST_IDLE);
    flush_o          = (state_q == ST_IDLE) && exc_valid_i && !rst_i;
    unique case (state_q)
      ST_W_MEPC: begin
        csr_req_o   = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MEPC);
        csr_wdata_o = pc_q & ~XLEN'(3);
      end
      ST_W_MCAUSE: begin
        csr_req_o   = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
      end
      ST_W_MTVAL: begin
        csr_req_o   = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MTVAL);
        csr_wdata_o = tval_q;
      end
      ST_W_MSTATUS_T: begin
        csr_req_o   = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o = ms_trap;
      end
      ST_W_MSTATUS_R: begin
        csr_req_o   = 1'b1;
        csr_addr_o  = CSR_AW'(CSR_MSTATUS);
        csr_wdata_o = ms_mret;
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_pc;
      end
      default: ;
    endcase
  end

endmodule
